sram_rd_streamer: RTL
=====================

// Module: sram_rd_streamer
// PURPOSE
// Read-side master for a 1-write/1-read SRAM with an active-low read enable and 1-cycle registered read data.
// On start it issues reads over a circular address range and absorbs the SRAM read latency in a 2-entry FIFO.
// Data leaves as a valid/ready stream with a last flag. It sits between a feature/weight buffer and its compute consumer.
// PARAMETERS
// WWORD  32  data word width, equal to the SRAM word width
// WADDR   5  SRAM address width
// DEPTH  24  number of valid SRAM entries; addresses wrap from DEPTH-1 to 0
// WLEN    8  width of the transfer length field
// PORTS
// clk        in   1      clock; all logic on posedge
// rst        in   1      synchronous reset, active-high
// start      in   1      one-cycle request; accepted only when busy==0
// base_addr  in   WADDR  first read address; sampled on accepted start
// len        in   WLEN   number of words; sampled on accepted start
// busy       out  1      high from the cycle after an accepted start until done
// done       out  1      one-cycle pulse after the last word is handed off
// err        out  1      one-cycle pulse when a start is rejected for base_addr>=DEPTH
// cena       out  1      SRAM read enable, active-low
// aa         out  WADDR  SRAM read address
// qa         in   WWORD  SRAM read data, valid the cycle after cena==0
// out_valid  out  1      stream data valid
// out_data   out  WWORD  stream data
// out_last   out  1      marks the final word of a transfer; qualified by out_valid
// out_ready  in   1      consumer accepts when out_valid&&out_ready
// BEHAVIOUR
// Reset values:
// - busy=0, done=0, err=0, cena=1, aa=0, out_valid=0, out_last=0, out_data=0.
// - FIFO emptied, in-flight read flag cleared, FSM to IDLE.
// - Reset mid-transfer drops all pending words; a qa returned the cycle after reset is ignored.
// FSM states:
// - IDLE -> RUN on start with base_addr<DEPTH and len!=0.
// - IDLE -> FIN on start with len==0. No SRAM access.
// - IDLE: start with base_addr>=DEPTH -> err=1 for one cycle, stay IDLE.
// - RUN -> FIN when all len reads are issued, no read is in flight, FIFO is empty and no pop is pending.
// - FIN: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
// - start while busy or in FIN is ignored; no err.
// Read issue, each RUN cycle:
// - cena=0 iff rem!=0 and (fifo_cnt + inflight - pop) < 2; pop = out_valid&&out_ready.
// - On issue: aa = cur address; next = (cur==DEPTH-1) ? 0 : cur+1; rem decrements.
// - cena is high whenever it does not issue, and in IDLE/FIN. aa holds its last value.
// - inflight = registered issue. When inflight==1, qa is written into the FIFO at that cycle's edge.
// - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
// Stream:
// - out_valid = fifo_cnt!=0; out_data/out_last come from the FIFO head.
// - out_last is set on the word from the read issued with rem==1.
// - A FIFO push and pop in the same cycle keep the count.
// - out_data/out_last are stable while out_valid&&!out_ready.
// Latency and throughput:
// - start sampled at edge 0; first cena=0 in cycle 1; qa valid cycle 2; out_valid first high cycle 3.
// - With out_ready held at 1: one word/cycle sustained.
// - done is asserted the cycle after the last handshake.
// Arithmetic: rem is WLEN bits with no wrap (stops at 0); address compare uses WADDR bits.
// TESTING
// - base=0, len=4, out_ready=1, mem[i]=i+100 -> out_data 100..103 on cycles 3..6; out_last on 103; done cycle 7.
// - base=22, len=4, DEPTH=24 -> aa sequence 22,23,0,1; out_last only on the 4th word.
// - len=6, out_ready toggled 1,0,0,1,... -> no word lost or duplicated; never more than 2 reads outstanding+buffered; order preserved.
// - len=0 -> done pulse cycle 1, cena never low; base_addr=30 -> err pulse, busy stays 0.
// - start pulsed again mid-transfer -> ignored; after done, new start with base=5,len=2 -> words mem[5],mem[6].
// - rst asserted cycle 4 of a len=8 transfer -> next cycle all outputs at reset values; following start runs cleanly.

Source files
------------

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: reads a circular SRAM address range and streams the words out through a 2-entry FIFO
module sram_rd_streamer #(
   parameter int WWORD = 32,
   parameter int WADDR = 5,
   parameter int DEPTH = 24,
   parameter int WLEN  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WADDR-1:0] base_addr,
   input  logic [WLEN-1:0]  len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             cena,
   output logic [WADDR-1:0] aa,
   input  logic [WWORD-1:0] qa,
   output logic             out_valid,
   output logic [WWORD-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t           state;
   logic [WADDR-1:0] cur;
   logic [WADDR-1:0] aa_q;
   logic [WLEN-1:0]  rem;
   logic             inflight;
   logic             inflight_last;
   logic [WWORD-1:0] fifo_data [2];
   logic [1:0]       fifo_last;
   logic             wp;
   logic             rp;
   logic [1:0]       cnt;
   logic             pop;
   logic             push;
   logic             issue;
   logic [2:0]       credit;
   assign pop       = out_valid && out_ready;
   assign push      = inflight;
   // slots already committed after this cycle's pop: buffered words plus the read in flight
   assign credit    = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
   assign issue     = state == RUN && rem != '0 && credit < 3'd2;
   assign cena      = !issue;
   assign aa        = issue ? cur : aa_q;
   assign out_valid = cnt != 2'd0;
   assign out_data  = fifo_data[rp];
   assign out_last  = fifo_last[rp] && out_valid;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         cur           <= '0;
         aa_q          <= '0;
         rem           <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_data     <= '{default: '0};
         fifo_last     <= '0;
         wp            <= 1'b0;
         rp            <= 1'b0;
         cnt           <= 2'd0;
      end else begin
         assert (!(push && !pop && cnt == 2'd2));
         done          <= 1'b0;
         err           <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && rem == WLEN'(1);
         if (issue) begin
            aa_q <= cur;
            cur  <= (cur == WADDR'(DEPTH - 1)) ? '0 : cur + WADDR'(1);
            rem  <= rem - WLEN'(1);
         end
         if (push) begin
            fifo_data[wp] <= qa;
            fifo_last[wp] <= inflight_last;
            wp            <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         case (state)
            IDLE: if (start) begin
               if ({1'b0, base_addr} >= (WADDR + 1)'(DEPTH)) err <= 1'b1;
               else if (len == '0) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else begin
                  state <= RUN;
                  busy  <= 1'b1;
                  cur   <= base_addr;
                  rem   <= len;
               end
            end
            RUN: if (rem == '0 && !inflight && cnt == {1'b0, pop}) begin
               state <= FIN;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
